// File: rtl/uart_tx_scheduler.sv
// Round-robin shared UART transmitter: two byte requesters, one tx line,
// 8N1/8N2 framing paced by an external one-cycle baud tick.
module uart_tx_scheduler #(
  parameter int unsigned stop_bits = 1
) (
  input  logic       reset_n,
  input  logic       clk,
  input  logic       baud_edge,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic       busy,
  output logic       tx
);

  generate
    if (stop_bits != 1 && stop_bits != 2) begin : g_bad_stop_bits
      $error("uart_tx_scheduler: stop_bits must be 1 or 2");
    end
  endgenerate

  localparam logic [1:0] stop_last = 2'(stop_bits);

  typedef enum logic [2:0] {IDLE, LOADED, START, DATA, STOP} state_t;

  state_t     state, state_next;
  logic [7:0] shift, shift_next;
  logic [3:0] bit_cnt, bit_cnt_next;
  logic [1:0] stop_cnt, stop_cnt_next;
  logic       last_grant, last_grant_next;
  logic       tx_q, tx_next;
  logic       grant0, grant1;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      shift      <= '0;
      bit_cnt    <= '0;
      stop_cnt   <= '0;
      last_grant <= 1'b1;
      tx_q       <= 1'b1;
    end else begin
      state      <= state_next;
      shift      <= shift_next;
      bit_cnt    <= bit_cnt_next;
      stop_cnt   <= stop_cnt_next;
      last_grant <= last_grant_next;
      tx_q       <= tx_next;
    end
  end

  always_comb begin
    // On contention the requester that did not win last time gets the line
    grant0          = req0_valid && (!req1_valid || last_grant);
    grant1          = req1_valid && (!req0_valid || !last_grant);
    req0_ready      = reset_n && (state == IDLE) && grant0;
    req1_ready      = reset_n && (state == IDLE) && grant1;
    state_next      = state;
    shift_next      = shift;
    bit_cnt_next    = bit_cnt;
    stop_cnt_next   = stop_cnt;
    last_grant_next = last_grant;
    tx_next         = tx_q;
    case (state)
      IDLE: begin
        if (req0_ready) begin
          shift_next      = req0_data;
          last_grant_next = 1'b0;
          state_next      = LOADED;
        end else if (req1_ready) begin
          shift_next      = req1_data;
          last_grant_next = 1'b1;
          state_next      = LOADED;
        end
      end
      LOADED: begin
        if (baud_edge) begin
          tx_next    = 1'b0;
          state_next = START;
        end
      end
      START: begin
        if (baud_edge) begin
          tx_next      = shift[0];
          shift_next   = {1'b0, shift[7:1]};
          bit_cnt_next = 4'd1;
          state_next   = DATA;
        end
      end
      DATA: begin
        if (baud_edge) begin
          if (bit_cnt < 4'd8) begin
            tx_next      = shift[0];
            shift_next   = {1'b0, shift[7:1]};
            bit_cnt_next = bit_cnt + 4'd1;
          end else begin
            tx_next       = 1'b1;
            stop_cnt_next = 2'd1;
            state_next    = STOP;
          end
        end
      end
      STOP: begin
        if (baud_edge) begin
          if (stop_cnt < stop_last) stop_cnt_next = stop_cnt + 2'd1;
          else state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        tx_next    = 1'b1;
      end
    endcase
  end

  assign busy = (state != IDLE);
  assign tx   = tx_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: a line receiver decodes frames at each
// baud edge and checks them against a queue of bytes expected in send order.
module tb_uart_tx_scheduler;
  localparam int unsigned STOP = 1;

  logic       clk = 1'b0;
  logic       reset_n, baud_edge, req0_valid, req1_valid;
  logic [7:0] req0_data, req1_data;
  logic       req0_ready, req1_ready, busy, tx;

  int unsigned passed = 0, total = 0;
  logic [7:0]  sb[$];
  logic        log_tx[$];
  logic        log_busy[$];
  int          starts[$];
  int          hs_id[$];
  int          edge_n = 0, rx_cnt = 0, hs_cnt = 0, r0_cyc = 0, rb_bad = 0;
  int          rx_st = 0, nb = 0, ph = 0;
  logic [7:0]  rx_byte = '0;

  uart_tx_scheduler #(.stop_bits(STOP)) dut (
    .reset_n(reset_n), .clk(clk), .baud_edge(baud_edge),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .busy(busy), .tx(tx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One clock: baud tick on every 4th cycle, inputs change on the falling edge
  task automatic step();
    baud_edge = (ph == 3);
    ph = (ph + 1) % 4;
    @(negedge clk);
  endtask

  task automatic wait_edges(input int n);
    int k = 0;
    while (log_tx.size() < n && k < 600) begin step(); k++; end
    chk("edge_timeout", log_tx.size() >= n, 1);
  endtask

  task automatic wait_hs(input int n);
    int k = 0;
    while (hs_cnt < n && k < 600) begin step(); k++; end
    chk("handshake_timeout", hs_cnt >= n, 1);
  endtask

  task automatic wait_rx(input int n);
    int k = 0;
    while (rx_cnt < n && k < 600) begin step(); k++; end
    chk("frame_timeout", rx_cnt >= n, 1);
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 200) begin step(); k++; end
    chk("idle_timeout", busy, 0);
  endtask

  always @(posedge clk) begin
    if (busy && (req0_ready || req1_ready)) rb_bad++;
    if (req0_ready) r0_cyc++;
    if (req0_valid && req0_ready) begin hs_id.push_back(0); hs_cnt++; end
    if (req1_valid && req1_ready) begin hs_id.push_back(1); hs_cnt++; end
    if (!reset_n) rx_st = 0;
    else if (baud_edge) begin
      #1;
      edge_n++;
      log_tx.push_back(tx);
      log_busy.push_back(busy);
      case (rx_st)
        0: if (tx == 1'b0) begin rx_st = 1; nb = 0; starts.push_back(edge_n); end
        1: begin
          rx_byte[nb] = tx;
          nb++;
          if (nb == 8) rx_st = 2;
        end
        default: begin
          chk("stop_bit", tx, 1);
          chk("frame_expected", sb.size() != 0, 1);
          if (sb.size() != 0) chk("frame_byte", rx_byte, sb.pop_front());
          rx_cnt++;
          rx_st = 0;
        end
      endcase
    end
  end

  initial begin
    logic [9:0] seq;
    int base_hs, base_rx;
    logic all_high;
    seq = 10'b1101001010;
    reset_n = 0; baud_edge = 0; req0_valid = 0; req1_valid = 0;
    req0_data = '0; req1_data = '0;
    repeat (3) step();
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_ready0", req0_ready, 0);
    chk("rst_ready1", req1_ready, 0);
    reset_n = 1; ph = 0;

    // Single byte 0xA5 from requester 0
    log_tx.delete(); log_busy.delete(); r0_cyc = 0;
    req0_valid = 1; req0_data = 8'hA5; sb.push_back(8'hA5);
    #1;
    chk("single_ready0", req0_ready, 1);
    chk("single_ready1", req1_ready, 0);
    repeat (3) step();
    req0_valid = 0;
    chk("single_ready_cycles", r0_cyc, 1);
    chk("single_busy_loaded", busy, 1);
    wait_edges(11);
    for (int i = 0; i < 10; i++) chk($sformatf("single_tx%0d", i), log_tx[i], seq[i]);
    chk("single_busy_last_stop", log_busy[9], 1);
    chk("single_busy_end", log_busy[10], 0);
    chk("single_tx_end", log_tx[10], 1);

    // Contention from reset: 0x11 / 0x22 alternate, requester 0 first
    reset_n = 0; step(); step(); reset_n = 1;
    req0_data = 8'h11; req1_data = 8'h22; req0_valid = 1; req1_valid = 1;
    sb.push_back(8'h11); sb.push_back(8'h22); sb.push_back(8'h11); sb.push_back(8'h22);
    hs_id.delete(); starts.delete(); base_hs = hs_cnt; base_rx = rx_cnt;
    #1;
    chk("cont_first_ready0", req0_ready, 1);
    chk("cont_first_ready1", req1_ready, 0);
    wait_hs(base_hs + 4);
    req0_valid = 0; req1_valid = 0;
    wait_rx(base_rx + 4);
    for (int i = 0; i < 4; i++) chk($sformatf("cont_grant%0d", i), hs_id[i], i % 2);
    for (int i = 1; i < 4; i++) chk("cont_spacing", starts[i] - starts[i-1], 10 + STOP);

    // Back-to-back stream on requester 1, data changed right after each capture
    base_hs = hs_cnt; base_rx = rx_cnt; starts.delete();
    req1_valid = 1; req1_data = 8'h00; sb.push_back(8'h00);
    wait_hs(base_hs + 1); req1_data = 8'hFF; sb.push_back(8'hFF);
    wait_hs(base_hs + 2); req1_data = 8'h55; sb.push_back(8'h55);
    wait_hs(base_hs + 3); req1_valid = 0; req1_data = 8'hE7;
    wait_rx(base_rx + 3);
    chk("stream_spacing01", starts[1] - starts[0], 10 + STOP);
    chk("stream_spacing12", starts[2] - starts[1], 10 + STOP);

    // Capture in the same cycle as a baud tick
    wait_idle();
    log_tx.delete(); log_busy.delete(); base_rx = rx_cnt;
    req0_valid = 1; req0_data = 8'h80; sb.push_back(8'h80); ph = 3;
    step();
    req0_valid = 0;
    chk("cap_busy", busy, 1);
    wait_edges(2);
    chk("cap_edge_tx", log_tx[0], 1);
    chk("cap_start_tx", log_tx[1], 0);
    wait_rx(base_rx + 1);

    // Reset during data bit 3 of 0x0F, then priority restored to requester 0
    wait_idle();
    log_tx.delete(); log_busy.delete();
    req0_valid = 1; req0_data = 8'h0F; sb.push_back(8'h0F);
    step();
    req0_valid = 0;
    wait_edges(5);
    step();
    reset_n = 0;
    step();
    chk("midrst_tx", tx, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_ready0", req0_ready, 0);
    chk("midrst_ready1", req1_ready, 0);
    sb.delete();
    step();
    reset_n = 1;
    hs_id.delete(); base_hs = hs_cnt; base_rx = rx_cnt;
    req0_data = 8'h3C; req1_data = 8'h5A; req0_valid = 1; req1_valid = 1;
    sb.push_back(8'h3C); sb.push_back(8'h5A);
    #1;
    chk("postrst_ready0", req0_ready, 1);
    wait_hs(base_hs + 1); req0_valid = 0;
    wait_hs(base_hs + 2); req1_valid = 0;
    chk("postrst_grant0", hs_id[0], 0);
    chk("postrst_grant1", hs_id[1], 1);
    wait_rx(base_rx + 2);

    // Requester 1 pulses valid only while busy: no transfer follows
    wait_idle();
    base_hs = hs_cnt; base_rx = rx_cnt;
    req0_valid = 1; req0_data = 8'h96; sb.push_back(8'h96);
    step();
    req0_valid = 0;
    repeat (5) step();
    req1_valid = 1; req1_data = 8'hC3;
    repeat (3) step();
    req1_valid = 0;
    wait_rx(base_rx + 1);
    log_tx.delete(); log_busy.delete();
    wait_edges(6);
    all_high = 1'b1;
    foreach (log_tx[i]) if (log_tx[i] !== 1'b1) all_high = 1'b0;
    chk("wd_handshakes", hs_cnt - base_hs, 1);
    chk("wd_tx_idle", all_high, 1);
    chk("wd_busy", busy, 0);

    chk("ready_while_busy", rb_bad, 0);
    chk("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
